// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous IROM address
// and offers {pc4, pc} to ID, redirecting on EX branches and CLINT trap entry/return.
module if_stage #(
  parameter logic [31:0] RESET_PC           = 32'h0000_0000,
  parameter int          IF_TO_ID_BUS_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          int_assert,
  input  logic [31:0]                   int_addr,
  input  logic                          hold_flag_if,
  input  logic                          id_allow_in,
  output logic [31:0]                   irom_addr,
  output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
  output logic                          if_to_id_valid
);

  localparam logic [1:0] BOOT = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;

  logic [1:0]  state_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] issued_pc_r;
  logic        if_ready_go_s;
  logic        xfer_s;
  logic        redirect_s;
  logic [31:0] redirect_pc_s;
  logic        unused_low_bits_s;

  assign if_ready_go_s  = !hold_flag_if;
  assign if_to_id_valid = (state_r == RUN) && if_ready_go_s;
  assign xfer_s         = if_to_id_valid && id_allow_in;
  assign if_to_id_bus   = {fetch_pc_r + 32'd4, fetch_pc_r};

  // Redirects are ignored in BOOT; the CLINT address outranks the branch target.
  assign redirect_s        = (state_r == RUN) && (int_assert || br_taken);
  assign unused_low_bits_s = ^{int_addr[1:0], br_target[1:0]};

  // Select the redirect target, word-aligned.
  always_comb begin
    redirect_pc_s = {br_target[31:2], 2'b00};
    if (int_assert) begin
      redirect_pc_s = {int_addr[31:2], 2'b00};
    end else begin
      redirect_pc_s = {br_target[31:2], 2'b00};
    end
  end

  // IROM address: re-present issued_pc while ID stalls so the ROM output stays put.
  always_comb begin
    irom_addr = issued_pc_r;
    if (redirect_s) begin
      irom_addr = redirect_pc_s;
    end else if (xfer_s) begin
      irom_addr = fetch_pc_r;
    end else begin
      irom_addr = issued_pc_r;
    end
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= BOOT;
      fetch_pc_r  <= RESET_PC;
      issued_pc_r <= RESET_PC;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= RUN;
        end
        RUN: begin
          state_r <= RUN;
          if (redirect_s) begin
            fetch_pc_r <= redirect_pc_s;
          end else if (xfer_s) begin
            fetch_pc_r  <= fetch_pc_r + 32'd4;
            issued_pc_r <= fetch_pc_r;
          end else begin
            fetch_pc_r <= fetch_pc_r;
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with RESET_PC = 0x100.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_target;
  logic        int_assert;
  logic [31:0] int_addr;
  logic        hold_flag_if;
  logic        id_allow_in;
  logic [31:0] irom_addr;
  logic [63:0] if_to_id_bus;
  logic        if_to_id_valid;

  int checks;
  int errors;

  if_stage #(.RESET_PC(32'h0000_0100), .IF_TO_ID_BUS_WIDTH(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .int_assert     (int_assert),
    .int_addr       (int_addr),
    .hold_flag_if   (hold_flag_if),
    .id_allow_in    (id_allow_in),
    .irom_addr      (irom_addr),
    .if_to_id_bus   (if_to_id_bus),
    .if_to_id_valid (if_to_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] bt;
    logic        ia;
    logic [31:0] iaddr;
    logic        hold;
    logic        allow;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] irom;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic br, logic [31:0] bt, logic ia, logic [31:0] iaddr,
                              logic hold, logic allow, logic valid, logic [31:0] pc,
                              logic [31:0] irom);
    vec_t v;
    v.br = br; v.bt = bt; v.ia = ia; v.iaddr = iaddr;
    v.hold = hold; v.allow = allow; v.valid = valid; v.pc = pc; v.irom = irom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic valid, input logic [31:0] pc,
                             input logic [31:0] irom);
    chk({tag, "_valid"}, {31'd0, if_to_id_valid}, {31'd0, valid});
    chk({tag, "_pc"},    if_to_id_bus[31:0],      pc);
    chk({tag, "_pc4"},   if_to_id_bus[63:32],     pc + 32'd4);
    chk({tag, "_irom"},  irom_addr,               irom);
  endtask

  task automatic drive(input vec_t v);
    br_taken     = v.br;
    br_target    = v.bt;
    int_assert   = v.ia;
    int_addr     = v.iaddr;
    hold_flag_if = v.hold;
    id_allow_in  = v.allow;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    drive(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

    //       br    target         int   addr           hold  allow valid pc             irom
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h100,      32'h100));      // BOOT
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h100,      32'h100));
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h104,      32'h104));
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h108,      32'h104));      // backpressure x3
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h108,      32'h104));
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h108,      32'h104));
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h108,      32'h108));
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h10C,      32'h10C));
    vecs.push_back(mk(1'b1, 32'h2003,   1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h110,      32'h2000));     // branch
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h2000,     32'h10C));      // issued_pc kept
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h2000,     32'h2000));
    vecs.push_back(mk(1'b1, 32'h400,    1'b1, 32'h80,     1'b0, 1'b1, 1'b1, 32'h2004,     32'h80));       // simultaneous
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h80,       32'h80));
    vecs.push_back(mk(1'b1, 32'h500,    1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h84,       32'h500));      // hold + branch
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h500,      32'h80));
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h500,      32'h500));
    vecs.push_back(mk(1'b0, 32'h0,      1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 32'h504,   32'hFFFF_FFFC)); // force wrap
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
    vecs.push_back(mk(1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,        32'h0));

    repeat (2) @(negedge clk);
    #1;
    chk_outputs("reset", 1'b0, 32'h100, 32'h100);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk_outputs($sformatf("v%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].irom);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a cycle, well before the next rising edge.
    drive(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
    #1;
    chk_outputs("pre_rst", 1'b1, 32'h4, 32'h4);
    rst_n = 1'b0;
    #1;
    chk_outputs("async_rst", 1'b0, 32'h100, 32'h100);

    // Re-boot: one BOOT cycle, then 0x100 offered and streaming resumes.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outputs("reboot0", 1'b0, 32'h100, 32'h100);
    @(negedge clk);
    #1;
    chk_outputs("reboot1", 1'b1, 32'h100, 32'h100);
    @(negedge clk);
    #1;
    chk_outputs("reboot2", 1'b1, 32'h104, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
